seqdet_stream_ctrl: RTL and testbench
=====================================

# seqdet_stream_ctrl

Sequencing controller for the sequence-detector lab datapath. It captures an 8-bit switch pattern and replays it into the detector FSM one bit per advance event, LSB first. Advance events come from either a divided-clock tick (auto mode) or a debounced button pulse (step mode). It clears the detector before each run, counts cycles in which the detector output `z` is high, and reports progress for the seven-segment/LED display logic. Everything runs on the board clock, and the detector is driven through a clock enable rather than a derived clock.

## Interface
Parameters:
- `NBITS`, 8: bits replayed per run; `pattern` width.
- `IDX_W`, 3: width of `bit_idx` (clog2 of `NBITS`).
- `HIT_W`, 4: width of `hit_count`.

Ports:
- `CLKPORT` in 1: board clock; sole clock.
- `reset_n` in 1: reset; asynchronous, active-low.
- `start` in 1: one-cycle pulse (edge-detected button); begins a run.
- `abort` in 1: one-cycle pulse; ends any run and returns to IDLE.
- `mode` in 1: 0 = auto (advance on `tick`), 1 = step (advance on `step`).
- `tick` in 1: one-cycle strobe from the clock divider.
- `step` in 1: one-cycle pulse (edge-detected button).
- `pattern` in NBITS: switch pattern; sampled at `start`.
- `z` in 1: detector output (Moore).
- `det_clr` out 1: synchronous clear to the detector.
- `det_en` out 1: clock enable to the detector.
- `x` out 1: serial bit to the detector.
- `busy` out 1: high from CLEAR through SAMPLE.
- `done` out 1: high in DONE.
- `bit_idx` out IDX_W: index of the next bit to send.
- `hit_count` out HIT_W: count of cycles with `z` high, saturating.

## Operation
- States: IDLE, CLEAR, ARM, STEP, SAMPLE, DONE.
- IDLE → CLEAR on `start`.
  - Latch `pattern` into `pat_q`.
  - Set `bit_idx` = 0 and `hit_count` = 0.
- CLEAR: `det_clr` = 1 for exactly one cycle, then → ARM.
- ARM: wait for the advance event: `adv` = `mode` ? `step` : `tick`. On `adv` → STEP.
- STEP: `det_en` = 1 for one cycle with `x` = `pat_q[bit_idx]`, then → SAMPLE.
- SAMPLE: `z` now reflects the updated detector state.
  - If `z` = 1, increment `hit_count`; it saturates at 2^HIT_W-1 and never wraps.
  - If `bit_idx` == NBITS-1 → DONE, with `bit_idx` holding at NBITS-1.
  - Otherwise increment `bit_idx` and → ARM.
- DONE: hold `hit_count` and `done`.
  - On `start` → CLEAR, with a fresh latch and counts cleared.
- `abort` in any state → IDLE next cycle.
  - `det_en` and `det_clr` are low in that cycle.
  - `hit_count` and `bit_idx` are held for display.
- `start` in CLEAR/ARM/STEP/SAMPLE is ignored.
- `start` and `abort` in the same cycle: `abort` wins.
- `adv` outside ARM is ignored. Events are not queued.
- Changes to `mode` take effect at the next ARM evaluation.
- `pattern` changes during a run have no effect because `pat_q` is used.
- `x` = `pat_q[bit_idx]` in all states; it only matters when `det_en` = 1.

## Timing
- Reset values: state IDLE, `pat_q` = 0, `det_clr` = 0, `det_en` = 0, `x` = 0, `busy` = 0, `done` = 0, `bit_idx` = 0, `hit_count` = 0.
- All outputs are registered or decoded from registered state; there is no input-to-output combinational path.
- `start` at cycle t: `det_clr` high at t+1, ARM at t+2.
- `adv` at cycle a while in ARM: `det_en` high at a+1, detector updates at the end of a+1, `z` sampled at a+2, `hit_count`/`bit_idx` updated at a+3.
- Minimum run length: 2 + NBITS × (1 + 1 + 1 wait) cycles. At least one ARM cycle occurs per bit.
- Max advance rate is one bit per 3 cycles. Faster `tick` pulses are dropped.
- `reset_n` asserted mid-run: all outputs return to reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after deassertion.

## Structure
- Shared header `seqdet_defs.vh` holds:
  - State encodings (`ST_IDLE` … `ST_DONE`, 3 bits).
  - The default `NBITS`/`HIT_W` values, reused by the top-level and the bench.
- One sub-module: `seqdet_hit_counter`, a saturating HIT_W-bit counter with `clr`, `inc` and async active-low reset.
- Controller FSM and bit index are kept in the top of this block.

## Test plan
- Reset: hold `reset_n` = 0 mid-run, at bit 4 → all outputs are 0 within the same cycle; state is IDLE after release.
- Auto run: `mode` = 0, `pattern` = 8'b0110_1101, bench detector model flags "11" (overlapping), `tick` every 5 cycles → `x` sequence 1,0,1,1,0,1,1,0 and 8 `det_en` pulses; `done` = 1, `hit_count` = 2, `bit_idx` = 7.
- Step mode: `mode` = 1, `pattern` = 8'hFF, 3 `step` pulses, `tick` toggling → exactly 3 `det_en` pulses, `bit_idx` = 3, `hit_count` = 2, `busy` = 1.
- Saturation: `HIT_W` = 2, `pattern` = 8'hFF, model with `z` = `x` → `hit_count` stops at 3 and does not wrap.
- Abort/conflict: `start` and `abort` in the same cycle during ARM → IDLE next cycle, no `det_clr`. `start` during STEP → ignored, `pat_q` unchanged.
- Back-to-back: `tick` every cycle → one bit per 3 cycles, and extra ticks produce no extra `det_en`. `start` in DONE → `det_clr` pulse, counts reset to 0.

Source files
------------

// File: rtl/seqdet_stream_ctrl_pkg.sv
// Shared definitions for the sequence-detector stream controller:
// controller state encoding and default sizing.
package seqdet_stream_ctrl_pkg;

  localparam int NBITS_DEF = 8;
  localparam int IDX_W_DEF = 3;
  localparam int HIT_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ARM    = 3'd2,
    ST_STEP   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/seqdet_stream_ctrl_if.sv
// Control/status bundle between the lab front panel, the stream controller
// and the detector FSM; the controller uses the slave side.
interface seqdet_stream_ctrl_if
  import seqdet_stream_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int HIT_W = HIT_W_DEF
);
  logic             start;
  logic             abort;
  logic             mode;
  logic             tick;
  logic             step;
  logic [NBITS-1:0] pattern;
  logic             z;
  logic             det_clr;
  logic             det_en;
  logic             x;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;
  logic [HIT_W-1:0] hit_count;

  modport slave (
    input  start, abort, mode, tick, step, pattern, z,
    output det_clr, det_en, x, busy, done, bit_idx, hit_count
  );

  modport master (
    output start, abort, mode, tick, step, pattern, z,
    input  det_clr, det_en, x, busy, done, bit_idx, hit_count
  );
endinterface

// File: rtl/seqdet_stream_ctrl_hit_counter.sv
// Saturating hit counter: clears on clr, counts on inc, sticks at all-ones.
module seqdet_stream_ctrl_hit_counter #(
  parameter int HIT_W = 4
) (
  input  logic             CLKPORT,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [HIT_W-1:0] count
);
  localparam logic [HIT_W-1:0] CNT_MAX = {HIT_W{1'b1}};

  logic [HIT_W-1:0] count_r;

  // Count register; clear has priority over increment.
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + HIT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
endmodule

// File: rtl/seqdet_stream_ctrl.sv
// Sequencing controller: latches a switch pattern and replays it LSB first
// into the detector through a clock enable, tallying cycles with z high.
module seqdet_stream_ctrl
  import seqdet_stream_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int HIT_W = HIT_W_DEF
) (
  input  logic                 CLKPORT,
  input  logic                 reset_n,
  seqdet_stream_ctrl_if.slave  bus
);
  state_e           state_r;
  state_e           state_s;
  logic [NBITS-1:0] pat_r;
  logic [IDX_W-1:0] idx_r;
  logic [HIT_W-1:0] hit_s;
  logic             adv_s;
  logic             last_s;
  logic             load_s;
  logic             sample_s;
  logic             det_clr_s;
  logic             det_en_s;
  logic             busy_s;
  logic             done_s;

  assign adv_s    = bus.mode ? bus.step : bus.tick;
  assign last_s   = (idx_r == IDX_W'(NBITS - 1));
  // An abort landing in SAMPLE freezes the counters for display.
  assign sample_s = (state_r == ST_SAMPLE) && !bus.abort;

  // Controller state register.
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    if (bus.abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_s = ST_CLEAR;
            load_s  = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        ST_CLEAR: state_s = ST_ARM;
        ST_ARM: begin
          if (adv_s) begin
            state_s = ST_STEP;
          end else begin
            state_s = ST_ARM;
          end
        end
        ST_STEP: state_s = ST_SAMPLE;
        ST_SAMPLE: begin
          if (last_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ARM;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Pattern latch and replay index.
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      pat_r <= '0;
      idx_r <= '0;
    end else if (load_s) begin
      pat_r <= bus.pattern;
      idx_r <= '0;
    end else if (sample_s && !last_s) begin
      pat_r <= pat_r;
      idx_r <= idx_r + IDX_W'(1);
    end else begin
      pat_r <= pat_r;
      idx_r <= idx_r;
    end
  end

  seqdet_stream_ctrl_hit_counter #(
    .HIT_W (HIT_W)
  ) u_hit_counter (
    .CLKPORT (CLKPORT),
    .reset_n (reset_n),
    .clr     (load_s),
    .inc     (sample_s && bus.z),
    .count   (hit_s)
  );

  // Output decode from the registered state only.
  always_comb begin
    det_clr_s = (state_r == ST_CLEAR);
    det_en_s  = (state_r == ST_STEP);
    busy_s    = (state_r == ST_CLEAR) || (state_r == ST_ARM) ||
                (state_r == ST_STEP)  || (state_r == ST_SAMPLE);
    done_s    = (state_r == ST_DONE);
  end

  assign bus.det_clr   = det_clr_s;
  assign bus.det_en    = det_en_s;
  assign bus.x         = pat_r[idx_r];
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.bit_idx   = idx_r;
  assign bus.hit_count = hit_s;
endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Scoreboard bench for seqdet_stream_ctrl: expected serial bits are queued
// at start and popped on every det_en; run results are checked at the end.
module tb_seqdet_stream_ctrl;
  import seqdet_stream_ctrl_pkg::*;

  logic CLKPORT = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLKPORT = ~CLKPORT;

  seqdet_stream_ctrl_if                bus ();
  seqdet_stream_ctrl_if #(.HIT_W(2))   sbus ();

  seqdet_stream_ctrl u_dut (
    .CLKPORT (CLKPORT),
    .reset_n (reset_n),
    .bus     (bus)
  );

  seqdet_stream_ctrl #(.HIT_W(2)) u_dut_sat (
    .CLKPORT (CLKPORT),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int en_cnt_s = 0;
  logic exp_x_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Detector model for the main DUT: Moore FSM flagging overlapping "11".
  logic prev_r, z_r, zs_r;
  always @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= 1'b0;
      z_r    <= 1'b0;
    end else if (bus.det_clr) begin
      prev_r <= 1'b0;
      z_r    <= 1'b0;
    end else if (bus.det_en) begin
      z_r    <= prev_r & bus.x;
      prev_r <= bus.x;
    end
  end
  assign bus.z = z_r;

  // Detector model for the saturation DUT: z follows the last bit sent.
  always @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) zs_r <= 1'b0;
    else if (sbus.det_clr) zs_r <= 1'b0;
    else if (sbus.det_en) zs_r <= sbus.x;
  end
  assign sbus.z = zs_r;

  // Monitor: compare each replayed bit against the scoreboard queue.
  always @(negedge CLKPORT) begin
    logic eb;
    if (reset_n) begin
      if (bus.det_clr) clr_cnt++;
      if (sbus.det_en) en_cnt_s++;
      if (bus.det_en) begin
        en_cnt++;
        if (exp_x_q.size() == 0) begin
          check_val("x_queue", exp_x_q.size(), 1);
        end else begin
          eb = exp_x_q.pop_front();
          check_val("x_bit", bus.x, eb);
        end
      end
    end
  end

  function automatic int ref_hits(logic [7:0] p, int n, int sat);
    int h = 0;
    for (int i = 1; i < n; i++) if (p[i] && p[i-1]) h++;
    return (h > sat) ? sat : h;
  endfunction

  task automatic push_bits(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) exp_x_q.push_back(p[i]);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLKPORT);
      #1;
    end
  endtask

  task automatic check_zero_outs(input string pfx);
    check_val({pfx, "_det_clr"}, bus.det_clr, 0);
    check_val({pfx, "_det_en"}, bus.det_en, 0);
    check_val({pfx, "_x"}, bus.x, 0);
    check_val({pfx, "_busy"}, bus.busy, 0);
    check_val({pfx, "_done"}, bus.done, 0);
    check_val({pfx, "_bit_idx"}, bus.bit_idx, 0);
    check_val({pfx, "_hit_count"}, bus.hit_count, 0);
  endtask

  task automatic do_start(input logic [7:0] p);
    bus.pattern = p;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0, clr0, n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.tick = 1'b0;
    bus.step = 1'b0; bus.pattern = 8'h00;
    sbus.start = 1'b0; sbus.abort = 1'b0; sbus.mode = 1'b0; sbus.tick = 1'b0;
    sbus.step = 1'b0; sbus.pattern = 8'h00;

    #1;
    check_zero_outs("rst");
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // Auto run: tick every 5 cycles, pattern changed after start.
    en0 = en_cnt;
    bus.mode = 1'b0;
    push_bits(8'b0110_1101, NBITS_DEF);
    do_start(8'b0110_1101);
    check_val("auto_det_clr", bus.det_clr, 1);
    check_val("auto_busy", bus.busy, 1);
    bus.pattern = 8'h00;
    for (int c = 0; c < 200 && !bus.done; c++) begin
      bus.tick = (c % 5 == 0);
      cyc(1);
    end
    bus.tick = 1'b0;
    check_val("auto_done", bus.done, 1);
    check_val("auto_busy_end", bus.busy, 0);
    check_val("auto_hits", bus.hit_count, ref_hits(8'b0110_1101, 8, 15));
    check_val("auto_bit_idx", bus.bit_idx, NBITS_DEF - 1);
    check_val("auto_en_pulses", en_cnt - en0, NBITS_DEF);
    check_val("auto_queue_left", exp_x_q.size(), 0);

    // Back-to-back ticks from DONE: fresh run, one bit per 3 cycles.
    en0 = en_cnt;
    push_bits(8'b1110_0011, NBITS_DEF);
    do_start(8'b1110_0011);
    check_val("b2b_det_clr", bus.det_clr, 1);
    check_val("b2b_hit_clr", bus.hit_count, 0);
    check_val("b2b_idx_clr", bus.bit_idx, 0);
    check_val("b2b_done_clr", bus.done, 0);
    bus.tick = 1'b1;
    n = 1;
    while (!bus.done && n < 100) begin
      cyc(1);
      n++;
    end
    bus.tick = 1'b0;
    check_val("b2b_run_len", n, 2 + NBITS_DEF * 3);
    check_val("b2b_en_pulses", en_cnt - en0, NBITS_DEF);
    check_val("b2b_hits", bus.hit_count, ref_hits(8'b1110_0011, 8, 15));

    // Step mode: three steps while tick toggles.
    en0 = en_cnt;
    bus.mode = 1'b1;
    push_bits(8'hFF, 3);
    do_start(8'hFF);
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      bus.tick = ~bus.tick;
      cyc(1);
      bus.step = 1'b0;
      for (int j = 0; j < 3; j++) begin
        bus.tick = ~bus.tick;
        cyc(1);
      end
    end
    bus.tick = 1'b0;
    check_val("step_en_pulses", en_cnt - en0, 3);
    check_val("step_bit_idx", bus.bit_idx, 3);
    check_val("step_hits", bus.hit_count, ref_hits(8'hFF, 3, 15));
    check_val("step_busy", bus.busy, 1);
    check_val("step_queue_left", exp_x_q.size(), 0);

    // start + abort together in ARM: abort wins, counts held.
    clr0 = clr_cnt;
    bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = 8'h00;
    cyc(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_done", bus.done, 0);
    check_val("abort_det_clr", bus.det_clr, 0);
    check_val("abort_idx_hold", bus.bit_idx, 3);
    check_val("abort_hit_hold", bus.hit_count, 2);
    cyc(1);
    check_val("abort_no_clr", clr_cnt - clr0, 0);
    check_val("abort_idle", bus.busy, 0);

    // start during STEP is ignored; latched pattern stays in use.
    en0 = en_cnt; clr0 = clr_cnt;
    bus.mode = 1'b0;
    push_bits(8'h55, NBITS_DEF);
    do_start(8'h55);
    bus.pattern = 8'hAA;
    cyc(1);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    check_val("ign_in_step", bus.det_en, 1);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_val("ign_no_clr", bus.det_clr, 0);
    bus.tick = 1'b1;
    for (int c = 0; c < 100 && !bus.done; c++) cyc(1);
    bus.tick = 1'b0;
    check_val("ign_done", bus.done, 1);
    check_val("ign_hits", bus.hit_count, ref_hits(8'h55, 8, 15));
    check_val("ign_en_pulses", en_cnt - en0, NBITS_DEF);
    check_val("ign_clr_pulses", clr_cnt - clr0, 1);
    check_val("ign_queue_left", exp_x_q.size(), 0);

    // Asynchronous reset at bit 4 of a run.
    push_bits(8'h3C, NBITS_DEF);
    do_start(8'h3C);
    bus.tick = 1'b1;
    for (int c = 0; c < 100 && bus.bit_idx != 3'd4; c++) cyc(1);
    check_val("mid_reached_bit4", bus.bit_idx, 4);
    reset_n = 1'b0;
    #1;
    check_zero_outs("midrst");
    exp_x_q.delete();
    bus.tick = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    check_val("post_rst_busy", bus.busy, 0);
    check_val("post_rst_done", bus.done, 0);

    // Saturation on the 2-bit hit counter instance.
    sbus.mode = 1'b0;
    sbus.pattern = 8'hFF;
    sbus.start = 1'b1;
    cyc(1);
    sbus.start = 1'b0;
    sbus.tick = 1'b1;
    for (int c = 0; c < 100 && !sbus.done; c++) cyc(1);
    sbus.tick = 1'b0;
    check_val("sat_done", sbus.done, 1);
    check_val("sat_hits", sbus.hit_count, 3);
    check_val("sat_en_pulses", en_cnt_s, NBITS_DEF);
    check_val("sat_bit_idx", sbus.bit_idx, NBITS_DEF - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
